// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 link types, frame constants and parity helper
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    XFER,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam int         PS2_FRAME_BITS   = 11;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // Odd parity: set when the byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchroniser for ps2_clk/ps2_data plus falling-edge strobe
`timescale 1ns/1ps
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic fall_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;

  // Two-stage synchronisers; idle lines read high so reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_s_o  = clk_sync_q[1];
  assign data_s_o = data_sync_q[1];
  assign fall_o   = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter (optional abort timer: PS2_TX_TIMEOUT_EN)
`timescale 1ns/1ps
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ps2_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_cnt_q;
  logic [9:0]       shift_q;
  logic             clk_oe_q;
  logic             data_oe_q;
  logic             ready_q;
  logic             done_q;
  logic             err_q;

  logic             clk_s;
  logic             data_s;
  logic             fall;
  logic             accept;

  ps2_line_sync u_line_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .clk_s_o    (clk_s),
    .data_s_o   (data_s),
    .fall_o     (fall)
  );

  assign accept = tx_valid & ready_q;

`ifdef PS2_TX_TIMEOUT_EN
  // The counter restarts at 1 when leaving RTS, so its value is cycles since the RTS cycle.
  logic timeout;
  assign timeout = (state_q inside {XFER, ACK, WAIT_IDLE}) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Transmit FSM: every line enable and status flag is a register so the pads never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      if (state_q inside {XFER, ACK, WAIT_IDLE}) begin
        cnt_q <= cnt_q + 1'b1;
      end
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            // Frame tail after the start bit: data LSB first, parity, stop.
            shift_q   <= {1'b1, odd_parity(tx_data), tx_data};
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            clk_oe_q  <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= INHIBIT;
          end else begin
            ready_q <= 1'b1;
          end
        end
        INHIBIT: begin
          if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
            data_oe_q <= 1'b1;
            state_q   <= RTS;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RTS: begin
          // Release the clock; the start bit stays on data until the first device fall.
          clk_oe_q <= 1'b0;
          cnt_q    <= CNT_W'(1);
          state_q  <= XFER;
        end
        XFER: begin
          if (fall) begin
            data_oe_q <= ~shift_q[0];
            shift_q   <= {1'b1, shift_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'(PS2_FRAME_BITS - 2)) begin
              state_q <= ACK;
            end
          end
        end
        ACK: begin
          if (fall) begin
            bit_cnt_q <= 4'(PS2_FRAME_BITS);
            if (data_s) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (clk_s && data_s) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      if (timeout) begin
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        done_q    <= 1'b0;
        err_q     <= 1'b1;
        state_q   <= IDLE;
      end
`endif
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = ready_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH     = 5000;
  localparam int TMO     = 6000;
  localparam int HALF_NS = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       clk_oe, data_oe, tx_ready, tx_done, tx_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_w, ps2_data_w;

  assign ps2_clk_w  = ~(clk_oe | dev_clk_low);
  assign ps2_data_w = ~(data_oe | dev_data_low);

  int          checks = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic        exp_q[$];

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk_w),
    .ps2_data    (ps2_data_w),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: run still active at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Expected wire bits: start, data LSB first, odd parity, stop.
  task automatic push_frame(input logic [7:0] d);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    exp_q.push_back((ones % 2) == 0);
    exp_q.push_back(1'b1);
  endtask

  task automatic send(input logic [7:0] d, input bit hold);
    int t = 0;
    while (tx_ready !== 1'b1 && t < 50000) begin
      @(negedge clk);
      t++;
    end
    if (tx_ready !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL send_ready: tx_ready=%b, wanted 1", tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    push_frame(d);
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  // Device: samples the start bit, then clocks 11 pulses reading data at each rising edge.
  task automatic dev_frame(input bit nack, input int stop_after, output logic par);
    int   t = 0;
    logic v, e;
    par = 1'b0;
    while (!(clk_oe === 1'b0 && data_oe === 1'b1) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!(clk_oe === 1'b0 && data_oe === 1'b1)) begin
      checks++;
      fails++;
      $display("FAIL dev_release: clk_oe=%b data_oe=%b, wanted 0 and 1", clk_oe, data_oe);
      return;
    end
    #(HALF_NS);
    for (int i = 0; i <= 11; i++) begin
      if (i > 0) begin
        if (i == 11 && !nack) begin
          dev_data_low = 1'b1;
          #1000;
        end
        dev_clk_low = 1'b1;
        #(HALF_NS);
        if (i == stop_after) return;
        dev_clk_low = 1'b0;
      end
      if (i <= 10) begin
        v = ps2_data_w;
        if (i == 9) par = v;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL wire_bit%0d: got %b, nothing expected", i, v);
        end else begin
          e = exp_q.pop_front();
          if (v !== e) begin
            fails++;
            $display("FAIL wire_bit%0d: got %b, expected %b", i, v, e);
          end
        end
      end
      if (i < 11) #(HALF_NS);
    end
    #1000;
    dev_data_low = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (clk_oe !== 1'b0) begin fails++; $display("FAIL rst_clk_oe: got %b, expected 0", clk_oe); end
    checks++; if (data_oe !== 1'b0) begin fails++; $display("FAIL rst_data_oe: got %b, expected 0", data_oe); end
    checks++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b, expected 1", tx_ready); end
    checks++; if (tx_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b, expected 0", tx_done); end
    checks++; if (tx_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b, expected 0", tx_err); end
  endtask

  task automatic test_set_leds();
    int   n = 0;
    int   d0 = done_cnt;
    int   e0 = err_cnt;
    logic par;
    send(PS2_CMD_SET_LEDS, 1'b0);
    while (clk_oe === 1'b1 && data_oe === 1'b0 && n < INH + 10) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n != INH) begin fails++; $display("FAIL inhibit_len: got %0d cycles, expected %0d", n, INH); end
    checks++; if (clk_oe !== 1'b1 || data_oe !== 1'b1) begin fails++; $display("FAIL rts: clk_oe=%b data_oe=%b, expected 1 1", clk_oe, data_oe); end
    @(negedge clk);
    checks++; if (clk_oe !== 1'b0 || data_oe !== 1'b1) begin fails++; $display("FAIL xfer_start: clk_oe=%b data_oe=%b, expected 0 1", clk_oe, data_oe); end
    dev_frame(1'b0, 0, par);
    checks++; if (par !== 1'b1) begin fails++; $display("FAIL led_parity: got %b, expected 1", par); end
    repeat (20) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL led_done: got %0d pulses, expected 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 != 0) begin fails++; $display("FAIL led_err: got %0d pulses, expected 0", err_cnt - e0); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL led_left: %0d bits unread, expected 0", exp_q.size()); end
    checks++; if (tx_ready !== 1'b1 || clk_oe !== 1'b0 || data_oe !== 1'b0) begin fails++; $display("FAIL led_idle: ready=%b clk_oe=%b data_oe=%b, expected 1 0 0", tx_ready, clk_oe, data_oe); end
  endtask

  task automatic test_back_to_back();
    int   t = 0;
    int   d0 = done_cnt;
    logic par;
    send(8'h00, 1'b1);
    tx_data = PS2_CMD_RESET;
    push_frame(PS2_CMD_RESET);
    dev_frame(1'b0, 0, par);
    checks++; if (par !== 1'b1) begin fails++; $display("FAIL b2b_parity0: got %b, expected 1", par); end
    @(negedge clk);
    while (tx_done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++; if (tx_done !== 1'b1) begin fails++; $display("FAIL b2b_done1: tx_done=%b, expected 1", tx_done); end
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1 || clk_oe !== 1'b0) begin fails++; $display("FAIL b2b_ready_rise: ready=%b clk_oe=%b, expected 1 0", tx_ready, clk_oe); end
    @(negedge clk);
    checks++; if (tx_ready !== 1'b0 || clk_oe !== 1'b1) begin fails++; $display("FAIL b2b_accept: ready=%b clk_oe=%b, expected 0 1", tx_ready, clk_oe); end
    tx_valid = 1'b0;
    dev_frame(1'b0, 0, par);
    checks++; if (par !== 1'b1) begin fails++; $display("FAIL b2b_parity1: got %b, expected 1", par); end
    repeat (20) @(negedge clk);
    checks++; if (done_cnt - d0 != 2) begin fails++; $display("FAIL b2b_done: got %0d pulses, expected 2", done_cnt - d0); end
  endtask

  task automatic test_nack();
    int   d0 = done_cnt;
    int   e0 = err_cnt;
    logic par;
    send(8'h55, 1'b0);
    dev_frame(1'b1, 0, par);
    repeat (20) @(negedge clk);
    checks++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL nack_err: got %0d pulses, expected 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 != 0) begin fails++; $display("FAIL nack_done: got %0d pulses, expected 0", done_cnt - d0); end
    checks++; if (clk_oe !== 1'b0 || data_oe !== 1'b0) begin fails++; $display("FAIL nack_lines: clk_oe=%b data_oe=%b, expected 0 0", clk_oe, data_oe); end
    checks++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL nack_ready: got %b, expected 1", tx_ready); end
  endtask

  task automatic test_timeout();
    int          t = 0;
    int unsigned r;
    int          e0 = err_cnt;
    send(8'h12, 1'b0);
    while (!(clk_oe === 1'b1 && data_oe === 1'b1) && t < INH + 10) begin
      @(negedge clk);
      t++;
    end
    r = cyc;
    t = 0;
`ifdef PS2_TX_TIMEOUT_EN
    while (tx_err !== 1'b1 && t < TMO + 100) begin
      @(negedge clk);
      t++;
    end
    checks++; if (cyc - r != TMO) begin fails++; $display("FAIL timeout_at: err after %0d cycles, expected %0d", cyc - r, TMO); end
    checks++; if (clk_oe !== 1'b0 || data_oe !== 1'b0) begin fails++; $display("FAIL timeout_lines: clk_oe=%b data_oe=%b, expected 0 0", clk_oe, data_oe); end
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL timeout_ready: got %b, expected 1", tx_ready); end
`else
    repeat (TMO + 100) @(negedge clk);
    checks++; if (err_cnt - e0 != 0) begin fails++; $display("FAIL notimeout_err: got %0d pulses, expected 0", err_cnt - e0); end
    checks++; if (clk_oe !== 1'b0 || data_oe !== 1'b1) begin fails++; $display("FAIL notimeout_hold: clk_oe=%b data_oe=%b, expected 0 1", clk_oe, data_oe); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (data_oe !== 1'b0 || tx_ready !== 1'b1) begin fails++; $display("FAIL notimeout_rst: data_oe=%b ready=%b, expected 0 1", data_oe, tx_ready); end
`endif
    exp_q.delete();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int   d0 = done_cnt;
    int   e0 = err_cnt;
    logic par;
    send(8'hA3, 1'b0);
    dev_frame(1'b0, 5, par);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (clk_oe !== 1'b0 || data_oe !== 1'b0) begin fails++; $display("FAIL midrst_lines: clk_oe=%b data_oe=%b, expected 0 0", clk_oe, data_oe); end
    checks++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b, expected 1", tx_ready); end
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    exp_q.delete();
    repeat (30) @(negedge clk);
    checks++; if (done_cnt - d0 != 0 || err_cnt - e0 != 0) begin fails++; $display("FAIL midrst_pulses: done=%0d err=%0d, expected 0 0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_busy_ignore();
    int   d0 = done_cnt;
    int   e0 = err_cnt;
    logic par;
    send(8'hF4, 1'b0);
    fork
      dev_frame(1'b0, 0, par);
      begin
        #(HALF_NS * 6);
        @(negedge clk);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    repeat (50) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL busy_done: got %0d pulses, expected 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 != 0) begin fails++; $display("FAIL busy_err: got %0d pulses, expected 0", err_cnt - e0); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL busy_left: %0d bits unread, expected 0", exp_q.size()); end
    checks++; if (clk_oe !== 1'b0 || tx_ready !== 1'b1) begin fails++; $display("FAIL busy_idle: clk_oe=%b ready=%b, expected 0 1", clk_oe, tx_ready); end
  endtask

  initial begin
    test_reset();
    test_set_leds();
    test_back_to_back();
    test_nack();
    test_timeout();
    test_mid_reset();
    test_busy_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
